// File: rtl/alu_share_ctrl_pkg.sv
// Shared encodings for the ALU sharing controller: widths, ALU opcodes, FSM states.
package alu_share_ctrl_pkg;

    localparam int DW  = 32;
    localparam int OPW = 5;

    typedef logic [OPW-1:0] op_t;

    localparam op_t OP_NOP = 5'b00000;
    localparam op_t OP_ADD = 5'b00001;
    localparam op_t OP_SUB = 5'b00010;
    localparam op_t OP_OR  = 5'b00100;
    localparam op_t OP_LUI = 5'b00110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bundle of both requester channels plus the ALU operand/result path.
interface alu_share_ctrl_if import alu_share_ctrl_pkg::*; ();

    logic          r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
    logic [DW-1:0] r0_a, r0_b, r0_pc;
    op_t           r0_op;

    logic          r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
    logic [DW-1:0] r1_a, r1_b, r1_pc;
    op_t           r1_op;

    logic [DW-1:0] rsp_c;
    logic          rsp_zero;

    logic [DW-1:0] alu_a, alu_b, alu_pc, alu_c;
    op_t           alu_op;
    logic          alu_zero;

    // Requesters and the external ALU side
    modport master (
        output r0_req_valid, r0_a, r0_b, r0_pc, r0_op, r0_rsp_ready,
        output r1_req_valid, r1_a, r1_b, r1_pc, r1_op, r1_rsp_ready,
        output alu_c, alu_zero,
        input  r0_req_ready, r0_rsp_valid, r1_req_ready, r1_rsp_valid,
        input  rsp_c, rsp_zero, alu_a, alu_b, alu_pc, alu_op
    );

    // Sharing controller side
    modport slave (
        input  r0_req_valid, r0_a, r0_b, r0_pc, r0_op, r0_rsp_ready,
        input  r1_req_valid, r1_a, r1_b, r1_pc, r1_op, r1_rsp_ready,
        input  alu_c, alu_zero,
        output r0_req_ready, r0_rsp_valid, r1_req_ready, r1_rsp_valid,
        output rsp_c, rsp_zero, alu_a, alu_b, alu_pc, alu_op
    );

endinterface

// File: rtl/alu_share_arb.sv
// Two-input one-hot arbiter; round-robin pointer when ALU_SHARE_RR_EN is defined,
// otherwise fixed priority with requester 0 winning.
module alu_share_arb (
`ifdef ALU_SHARE_RR_EN
    input  logic       clk,
    input  logic       rstn,
    input  logic       adv_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef ALU_SHARE_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
        else                gnt_o = req_i;
    end

    // Preference moves to the requester that did not just win
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) ptr_d = ~gnt_o[1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
    end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters (IDLE/EXEC/RESP FSM).
// Arbitration is round-robin when ALU_SHARE_RR_EN is defined, fixed priority otherwise.
module alu_share_ctrl import alu_share_ctrl_pkg::*; (
    input  logic           clk,
    input  logic           rstn,
    alu_share_ctrl_if.slave bus
);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_pc_q, alu_pc_d;
    op_t           alu_op_q, alu_op_d;
    logic [DW-1:0] rsp_c_q, rsp_c_d;
    logic          rsp_zero_q, rsp_zero_d;

    logic [1:0] req, gnt;
    logic       rsp_hs, take;

    assign req    = {bus.r1_req_valid, bus.r0_req_valid};
    assign rsp_hs = (state_q == RESP) && (grant_q ? bus.r1_rsp_ready : bus.r0_rsp_ready);
    // A new op may be accepted from IDLE or in the same cycle a response completes
    assign take   = ((state_q == IDLE) || rsp_hs) && (req != 2'b00);

    alu_share_arb u_arb (
`ifdef ALU_SHARE_RR_EN
        .clk   (clk),
        .rstn  (rstn),
        .adv_i (take),
`endif
        .req_i (req),
        .gnt_o (gnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_pc_q   <= '0;
            alu_op_q   <= OP_NOP;
            rsp_c_q    <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_pc_q   <= alu_pc_d;
            alu_op_q   <= alu_op_d;
            rsp_c_q    <= rsp_c_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_pc_d   = alu_pc_q;
        alu_op_d   = alu_op_q;
        rsp_c_d    = rsp_c_q;
        rsp_zero_d = rsp_zero_q;
        case (state_q)
            IDLE: if (take) state_d = EXEC;
            EXEC: begin
                state_d    = RESP;
                rsp_c_d    = bus.alu_c;
                rsp_zero_d = bus.alu_zero;
            end
            RESP: if (rsp_hs) state_d = take ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
        if (take) begin
            grant_d  = gnt[1];
            alu_a_d  = gnt[1] ? bus.r1_a  : bus.r0_a;
            alu_b_d  = gnt[1] ? bus.r1_b  : bus.r0_b;
            alu_pc_d = gnt[1] ? bus.r1_pc : bus.r0_pc;
            alu_op_d = gnt[1] ? bus.r1_op : bus.r0_op;
        end
    end

    always_comb begin
        bus.r0_req_ready = take & gnt[0];
        bus.r1_req_ready = take & gnt[1];
        bus.r0_rsp_valid = (state_q == RESP) && !grant_q;
        bus.r1_rsp_valid = (state_q == RESP) &&  grant_q;
    end

    assign bus.rsp_c    = rsp_c_q;
    assign bus.rsp_zero = rsp_zero_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_pc   = alu_pc_q;
    assign bus.alu_op   = alu_op_q;

endmodule
